// File: rtl/decoder1to2_pkg.sv
// Shared types and constants for the registered 1-to-2 decoder.
// Output vector layout: bit 1 drives o1, bit 0 drives o0.
package decoder1to2_pkg;

    localparam logic DEC_SEL_O0 = 1'b0;
    localparam logic DEC_SEL_O1 = 1'b1;

    typedef logic [1:0] dec_out_t;

    localparam dec_out_t DEC_OUT_IDLE = 2'b00;

    // One-hot decode of the select bit, forced idle while disabled.
    function automatic dec_out_t dec_decode(input logic en, input logic sel);
        dec_out_t v;
        v = DEC_OUT_IDLE;
        if (en) begin
            v = (sel == DEC_SEL_O1) ? dec_out_t'(2'b10) : dec_out_t'(2'b01);
        end
        return v;
    endfunction

endpackage

// File: rtl/decoder1to2_with_enable_if.sv
// Select/enable inputs and decoded strobes of the 1-to-2 decoder.
// The master drives i/en; the decoder (slave) drives o1/o0.
interface decoder1to2_with_enable_if;

    logic i;
    logic en;
    logic o1;
    logic o0;

    modport master (
        output i,
        output en,
        input  o1,
        input  o0
    );

    modport slave (
        input  i,
        input  en,
        output o1,
        output o0
    );

endinterface

// File: rtl/sync2.sv
// Two-flop synchronizer with asynchronous active-high reset to 0.
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/decoder1to2_with_enable.sv
// Registered 1-to-2 decoder with enable; outputs are one-hot or idle.
// Define DECODER1TO2_WITH_ENABLE_SYNC_EN to pass i/en through two-flop synchronizers.
module decoder1to2_with_enable
    import decoder1to2_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    decoder1to2_with_enable_if.slave bus
);

    logic     w_sel;
    logic     w_en;
    dec_out_t w_dec;
    dec_out_t r_out;

`ifdef DECODER1TO2_WITH_ENABLE_SYNC_EN
    sync2 u_sync_sel (
        .clk (clk),
        .rst (rst),
        .i_d (bus.i),
        .o_q (w_sel)
    );

    sync2 u_sync_en (
        .clk (clk),
        .rst (rst),
        .i_d (bus.en),
        .o_q (w_en)
    );
`else
    assign w_sel = bus.i;
    assign w_en  = bus.en;
`endif

    always_comb begin
        w_dec = DEC_OUT_IDLE;
        w_dec = dec_decode(w_en, w_sel);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out <= DEC_OUT_IDLE;
        end else begin
            r_out <= w_dec;
        end
    end

    assign bus.o1 = r_out[1];
    assign bus.o0 = r_out[0];

endmodule

// File: tb/tb_decoder1to2_with_enable.sv
// Self-checking bench for decoder1to2_with_enable: queue-based reference model
// checked every cycle, plus directed vectors with literal expectations.
module tb_decoder1to2_with_enable;

`ifdef DECODER1TO2_WITH_ENABLE_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic clk;
    logic rst;
    int   total;
    int   bad;

    decoder1to2_with_enable_if bus ();

    decoder1to2_with_enable dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: input pairs sampled since reset; output follows the pair LAT
    // edges old, and stays idle until that many live samples exist.
    logic [1:0] hist_q[$];

    function automatic logic [1:0] ref_out(input logic e, input logic s);
        if (e !== 1'b1) return 2'b00;
        if (s === 1'b1) return 2'b10;
        return 2'b01;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_q.delete();
        end else begin
            hist_q.push_back({bus.en, bus.i});
            if (hist_q.size() > LAT) void'(hist_q.pop_front());
        end
    end

    always @(negedge clk) begin
        logic [1:0] exp_v;
        logic [1:0] act_v;
        exp_v = 2'b00;
        if (!rst && hist_q.size() == LAT) exp_v = ref_out(hist_q[0][1], hist_q[0][0]);
        act_v = {bus.o1, bus.o0};
        total++;
        if (act_v !== exp_v) begin
            bad++;
            $display("FAIL model t=%0t got=%b want=%b", $time, act_v, exp_v);
        end
        total++;
        if ((bus.o1 & bus.o0) !== 1'b0) begin
            bad++;
            $display("FAIL onehot t=%0t got o1=%b o0=%b want not both", $time, bus.o1, bus.o0);
        end
    end

    task automatic check_lit(input string name, input logic [1:0] want);
        logic [1:0] got;
        got = {bus.o1, bus.o0};
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s t=%0t got={o1,o0}=%b want=%b", name, $time, got, want);
        end
    endtask

    // Drive a pair at the falling edge and wait until it has reached the outputs.
    task automatic settle(input logic e, input logic s);
        @(negedge clk);
        bus.en = e;
        bus.i  = s;
        repeat (LAT) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog t=%0t got=running want=finished", $time);
        $fatal(1);
    end

    initial begin
        logic [1:0] tog_want[4];
        logic       tog_sel[4];
        tog_sel  = '{1'b0, 1'b1, 1'b0, 1'b1};
        tog_want = '{2'b01, 2'b10, 2'b01, 2'b10};
        total  = 0;
        bad    = 0;
        rst    = 1'b0;
        bus.en = 1'b1;
        bus.i  = 1'b1;
        #2 rst = 1'b1;
        #1 check_lit("reset_async", 2'b00);
        repeat (3) @(negedge clk);
        check_lit("reset_hold", 2'b00);
        bus.en = 1'b0;
        bus.i  = 1'b0;
        rst    = 1'b0;
        #1 check_lit("reset_release", 2'b00);

        settle(1'b0, 1'b0);
        check_lit("dis_i0", 2'b00);
        settle(1'b0, 1'b1);
        check_lit("dis_i1", 2'b00);
        settle(1'b1, 1'b0);
        check_lit("en_sel0", 2'b01);
        settle(1'b1, 1'b1);
        check_lit("en_sel1", 2'b10);
        settle(1'b1, 1'b0);
        check_lit("en_sel1_to_0", 2'b01);
        // Simultaneous en and i change: no intermediate value should appear.
        settle(1'b0, 1'b1);
        check_lit("both_change_off", 2'b00);
        settle(1'b1, 1'b0);
        check_lit("both_change_on", 2'b01);

        // Toggle i each cycle; output at a falling edge reflects the pair
        // driven LAT falling edges earlier.
        for (int n = 0; n < 4 + LAT; n++) begin
            @(negedge clk);
            if (n >= LAT) check_lit($sformatf("toggle%0d", n - LAT), tog_want[n - LAT]);
            if (n < 4) bus.i = tog_sel[n];
        end

        settle(1'b1, 1'b1);
        check_lit("pre_disable", 2'b10);
        settle(1'b0, 1'b1);
        check_lit("disable_mid", 2'b00);

        settle(1'b1, 1'b0);
        check_lit("pre_reset", 2'b01);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check_lit("reset_mid_async", 2'b00);
        @(negedge clk);
        check_lit("reset_mid_hold", 2'b00);
        rst = 1'b0;
        #1 check_lit("reset_mid_release", 2'b00);
        repeat (LAT) @(posedge clk);
        #1 check_lit("reset_refill", 2'b01);

        repeat (3) @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
